bip_exec_controller: RTL and testbench

BIP_EXEC_CONTROLLER -- requirements
Module: bip_exec_controller

---
 rtl/bip_exec_controller.sv | 237 +++++++++++++++++++++++
 tb/tb_bip_exec_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_exec_controller.sv
// ---------------------------------------------------------------------------
// bip_exec_controller
//
// Purpose:
//   Execution controller for a small BIP-style CPU. It gates the CPU clock
//   enable for free-running (RUN) and single-instruction (STEP) execution,
//   stops in front of an HLT word so it is never executed, and can stream the
//   first DUMP_DEPTH data-memory words out over a valid/ready interface. The
//   data-memory port is shared: the CPU owns it outside a dump, the dump
//   engine owns it during a dump.
//
// Parameters:
//   DUMP_DEPTH : words streamed per dump, starting at address 0 (1..2048)
//   CNT_W      : width of the executed-cycle counter
//
// Ports:
//   i_clk            rising-edge clock for all state
//   i_reset          synchronous, active-high reset
//   i_cmd_run        single-cycle strobe: start free-running execution
//   i_cmd_step       single-cycle strobe: execute one instruction
//   i_cmd_dump       single-cycle strobe: stream data memory out
//   i_instruction    current program-memory word, opcode in [15:11]
//   i_cpu_addr_dm    CPU data-memory address
//   i_cpu_rd/_wr     CPU data-memory read / write request
//   i_dm_data        data-memory read data, valid the cycle after o_dm_rd
//   o_cpu_en         CPU advances one instruction on an edge where this is 1
//   o_dm_addr        arbitrated data-memory address
//   o_dm_rd/_wr      arbitrated data-memory read / write
//   o_dump_data      dump word
//   o_dump_addr      address of the dump word
//   o_dump_valid     dump word is valid
//   i_dump_ready     consumer accepts the dump word
//   o_dump_done      one-cycle pulse after the last dump word is accepted
//   o_halted         CPU is halted (also during a dump started from halt)
//   o_cycle_count    number of cycles with o_cpu_en=1, saturating
// ---------------------------------------------------------------------------
module bip_exec_controller #(
    parameter int DUMP_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_run,
    input  logic             i_cmd_step,
    input  logic             i_cmd_dump,
    input  logic [15:0]      i_instruction,
    input  logic [10:0]      i_cpu_addr_dm,
    input  logic             i_cpu_rd,
    input  logic             i_cpu_wr,
    input  logic [15:0]      i_dm_data,
    output logic             o_cpu_en,
    output logic [10:0]      o_dm_addr,
    output logic             o_dm_rd,
    output logic             o_dm_wr,
    output logic [15:0]      o_dump_data,
    output logic [10:0]      o_dump_addr,
    output logic             o_dump_valid,
    input  logic             i_dump_ready,
    output logic             o_dump_done,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_STEP     = 3'd2,
        S_HALT     = 3'd3,
        S_DUMP_RD  = 3'd4,
        S_DUMP_CAP = 3'd5,
        S_DUMP_OUT = 3'd6
    } state_t;

    localparam logic [10:0]      LAST_PTR = 11'(DUMP_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t            r_state;
    logic              r_ret_halt;     // 1: dump returns to HALT, 0: to IDLE
    logic [10:0]       r_ptr;
    logic [15:0]       r_dump_data;
    logic [10:0]       r_dump_addr;
    logic              r_dump_done;
    logic [CNT_W-1:0]  r_cycle_count;

    logic              w_halt_op;
    logic              w_in_dump;
    logic              w_cpu_en;

    // Instruction decode and CPU enable; the enable drops on an HLT word so
    // the CPU stops in front of it instead of executing it.
    always_comb begin
        w_halt_op = (i_instruction[15:11] == 5'b00000);
        w_in_dump = (r_state == S_DUMP_RD) || (r_state == S_DUMP_CAP) ||
                    (r_state == S_DUMP_OUT);
        w_cpu_en  = 1'b0;
        if (!i_reset && ((r_state == S_RUN) || (r_state == S_STEP)) && !w_halt_op) begin
            w_cpu_en = 1'b1;
        end else begin
            w_cpu_en = 1'b0;
        end
    end

    // Data-memory arbitration: the CPU owns the port except while dumping.
    // The dump engine never writes, so o_dm_wr is forced low in dump states.
    always_comb begin
        o_dm_addr = i_cpu_addr_dm;
        o_dm_rd   = 1'b0;
        o_dm_wr   = 1'b0;
        if (i_reset || !w_in_dump) begin
            o_dm_addr = i_cpu_addr_dm;
            o_dm_rd   = i_cpu_rd & w_cpu_en;
            o_dm_wr   = i_cpu_wr & w_cpu_en;
        end else begin
            o_dm_addr = r_ptr;
            o_dm_rd   = (r_state == S_DUMP_RD);
            o_dm_wr   = 1'b0;
        end
    end

    // Status and dump outputs; all held at zero while reset is asserted,
    // even in the reset cycle itself before the state has been cleared.
    always_comb begin
        o_cpu_en      = w_cpu_en;
        o_dump_valid  = 1'b0;
        o_halted      = 1'b0;
        o_dump_data   = 16'h0000;
        o_dump_addr   = 11'h000;
        o_dump_done   = 1'b0;
        o_cycle_count = '0;
        if (!i_reset) begin
            o_dump_valid  = (r_state == S_DUMP_OUT);
            o_halted      = (r_state == S_HALT) || (w_in_dump && r_ret_halt);
            o_dump_data   = r_dump_data;
            o_dump_addr   = r_dump_addr;
            o_dump_done   = r_dump_done;
            o_cycle_count = r_cycle_count;
        end else begin
            o_dump_valid  = 1'b0;
            o_halted      = 1'b0;
            o_dump_data   = 16'h0000;
            o_dump_addr   = 11'h000;
            o_dump_done   = 1'b0;
            o_cycle_count = '0;
        end
    end

    // Control FSM, dump pointer/capture registers and saturating cycle counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_ret_halt    <= 1'b0;
            r_ptr         <= 11'h000;
            r_dump_data   <= 16'h0000;
            r_dump_addr   <= 11'h000;
            r_dump_done   <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            r_dump_done <= 1'b0;

            if (w_cpu_en && (r_cycle_count != CNT_MAX)) begin
                r_cycle_count <= r_cycle_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_cycle_count <= r_cycle_count;
            end

            case (r_state)
                S_IDLE: begin
                    // Simultaneous strobes resolve RUN > STEP > DUMP.
                    if (i_cmd_run) begin
                        r_state <= S_RUN;
                    end else if (i_cmd_step) begin
                        r_state <= S_STEP;
                    end else if (i_cmd_dump) begin
                        r_ret_halt <= 1'b0;
                        r_state    <= S_DUMP_RD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (w_halt_op) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_STEP: begin
                    if (w_halt_op) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    // Only a dump (or reset) leaves HALT.
                    if (i_cmd_dump) begin
                        r_ret_halt <= 1'b1;
                        r_state    <= S_DUMP_RD;
                    end else begin
                        r_state <= S_HALT;
                    end
                end
                S_DUMP_RD: begin
                    r_state <= S_DUMP_CAP;
                end
                S_DUMP_CAP: begin
                    // Read data returned for the address issued last cycle.
                    r_dump_data <= i_dm_data;
                    r_dump_addr <= r_ptr;
                    r_state     <= S_DUMP_OUT;
                end
                S_DUMP_OUT: begin
                    if (i_dump_ready) begin
                        if (r_ptr == LAST_PTR) begin
                            r_ptr       <= 11'h000;
                            r_dump_done <= 1'b1;
                            if (r_ret_halt) begin
                                r_state <= S_HALT;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_ptr   <= r_ptr + 11'd1;
                            r_state <= S_DUMP_RD;
                        end
                    end else begin
                        r_state <= S_DUMP_OUT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bip_exec_controller.sv
module tb_bip_exec_controller;

    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_run = 1'b0, cmd_step = 1'b0, cmd_dump = 1'b0;
    logic [15:0]   instr = 16'h2001;
    logic [10:0]   cpu_addr = 11'h000;
    logic          cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [15:0]   dm_data = 16'h0000;
    logic          dump_ready = 1'b0;

    logic          o_cpu_en, o_dm_rd, o_dm_wr, o_dump_valid, o_dump_done, o_halted;
    logic [10:0]   o_dm_addr, o_dump_addr;
    logic [15:0]   o_dump_data;
    logic [CW-1:0] o_cycle_count;

    bip_exec_controller #(.DUMP_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_cmd_run(cmd_run), .i_cmd_step(cmd_step), .i_cmd_dump(cmd_dump),
        .i_instruction(instr), .i_cpu_addr_dm(cpu_addr),
        .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr), .i_dm_data(dm_data),
        .o_cpu_en(o_cpu_en), .o_dm_addr(o_dm_addr), .o_dm_rd(o_dm_rd), .o_dm_wr(o_dm_wr),
        .o_dump_data(o_dump_data), .o_dump_addr(o_dump_addr), .o_dump_valid(o_dump_valid),
        .i_dump_ready(dump_ready), .o_dump_done(o_dump_done), .o_halted(o_halted),
        .o_cycle_count(o_cycle_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem [0:2047];

    // Behavioural model: mode 0=idle 1=run 2=single step 3=halted,
    // plus a dump in progress described by word pointer and phase 0/1/2
    // (issue read, receive data, offer word).
    int          m_mode = 0;
    bit          m_dump = 0;
    int          m_phase = 0;
    int          m_ptr = 0;
    bit          m_ret = 0;
    int          m_cnt = 0;
    logic [15:0] m_data = 16'h0000;
    logic [10:0] m_daddr = 11'h000;
    bit          m_done = 0;
    bit          e_en_now = 0;

    logic        s_rd = 1'b0;
    logic [10:0] s_addr = 11'h000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output with the model on the falling edge.
    task automatic settle();
        bit          hlt;
        bit          e_rd, e_wr, e_valid, e_halted;
        logic [10:0] e_addr;
        @(negedge clk);
        hlt      = (instr[15:11] == 5'd0);
        e_en_now = !rst && !m_dump && (m_mode == 1 || m_mode == 2) && !hlt;
        if (rst || !m_dump) begin
            e_addr = cpu_addr;
            e_rd   = cpu_rd && e_en_now;
            e_wr   = cpu_wr && e_en_now;
        end else begin
            e_addr = 11'(m_ptr);
            e_rd   = (m_phase == 0);
            e_wr   = 1'b0;
        end
        e_valid  = !rst && m_dump && (m_phase == 2);
        e_halted = !rst && (m_dump ? m_ret : (m_mode == 3));
        chk("cpu_en",      32'(o_cpu_en),      32'(e_en_now));
        chk("dm_addr",     32'(o_dm_addr),     32'(e_addr));
        chk("dm_rd",       32'(o_dm_rd),       32'(e_rd));
        chk("dm_wr",       32'(o_dm_wr),       32'(e_wr));
        chk("dump_valid",  32'(o_dump_valid),  32'(e_valid));
        chk("halted",      32'(o_halted),      32'(e_halted));
        chk("dump_data",   32'(o_dump_data),   rst ? 32'd0 : 32'(m_data));
        chk("dump_addr",   32'(o_dump_addr),   rst ? 32'd0 : 32'(m_daddr));
        chk("dump_done",   32'(o_dump_done),   rst ? 32'd0 : 32'(m_done));
        chk("cycle_count", 32'(o_cycle_count), rst ? 32'd0 : 32'(m_cnt));
        s_rd   = o_dm_rd;
        s_addr = o_dm_addr;
    endtask

    // Clock edge: advance the model with the inputs seen at this edge, then
    // return read data for the address the DUT presented (garbage otherwise).
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_dump = 0; m_phase = 0; m_ptr = 0; m_ret = 0;
            m_cnt = 0; m_data = 16'h0000; m_daddr = 11'h000; m_done = 0;
        end else begin
            if (e_en_now && m_cnt < CMAX) m_cnt++;
            m_done = 0;
            if (m_dump) begin
                if (m_phase == 0) m_phase = 1;
                else if (m_phase == 1) begin
                    m_data  = mem[m_ptr];
                    m_daddr = 11'(m_ptr);
                    m_phase = 2;
                end else if (dump_ready) begin
                    if (m_ptr == DEPTH - 1) begin
                        m_ptr = 0; m_done = 1; m_dump = 0;
                        m_mode = m_ret ? 3 : 0;
                    end else begin
                        m_ptr++; m_phase = 0;
                    end
                end
            end else begin
                case (m_mode)
                    0: if (cmd_run) m_mode = 1;
                       else if (cmd_step) m_mode = 2;
                       else if (cmd_dump) begin m_dump = 1; m_phase = 0; m_ret = 0; end
                    1: if (instr[15:11] == 5'd0) m_mode = 3;
                    2: m_mode = (instr[15:11] == 5'd0) ? 3 : 0;
                    3: if (cmd_dump) begin m_dump = 1; m_phase = 0; m_ret = 1; end
                    default: m_mode = 0;
                endcase
            end
        end
        #1;
        dm_data = s_rd ? mem[s_addr] : 16'($urandom);
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, stall, done_cnt;
        bit got_done;
        logic [15:0] held;

        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h000A; mem[1] = 16'h000B; mem[2] = 16'h000C; mem[3] = 16'h000D;

        // Reset
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        settle();
        chk("rst_cpu_en", 32'(o_cpu_en), 32'd0);
        chk("rst_count",  32'(o_cycle_count), 32'd0);
        chk("rst_halted", 32'(o_halted), 32'd0);
        advance();

        // Run LDI 4, STO 2, ADD 1, HLT
        cmd_run = 1'b1; instr = 16'h1804;
        cyc();
        cmd_run = 1'b0;
        settle(); chk("run_en0", 32'(o_cpu_en), 32'd1); advance();
        instr = 16'h0802; cpu_wr = 1'b1; cpu_addr = 11'h005;
        settle();
        chk("run_en1", 32'(o_cpu_en), 32'd1);
        chk("run_dm_wr", 32'(o_dm_wr), 32'd1);
        chk("run_dm_addr", 32'(o_dm_addr), 32'h005);
        advance();
        instr = 16'h2001;
        settle(); chk("run_en2", 32'(o_cpu_en), 32'd1); advance();
        instr = 16'h0000;
        settle(); chk("run_hlt_en", 32'(o_cpu_en), 32'd0); advance();
        settle();
        chk("run_halted", 32'(o_halted), 32'd1);
        chk("run_count", 32'(o_cycle_count), 32'd3);
        advance();

        // Dump from HALT with backpressure on word 1
        cmd_dump = 1'b1; cmd_run = 1'b1;
        cyc();
        cmd_dump = 1'b0; cmd_run = 1'b0;
        settle();
        chk("arb_dump_wr", 32'(o_dm_wr), 32'd0);
        chk("arb_dump_addr", 32'(o_dm_addr), 32'd0);
        chk("arb_dump_rd", 32'(o_dm_rd), 32'd1);
        advance();
        hs = 0; stall = 0; done_cnt = 0; got_done = 0; held = 16'h0000;
        for (int c = 0; c < 60 && !got_done; c++) begin
            dump_ready = !(hs == 1 && stall < 2);
            settle();
            if (o_dump_valid) begin
                if (!dump_ready) begin
                    if (stall > 0) chk("stall_stable", 32'(o_dump_data), 32'(held));
                    held = o_dump_data;
                    stall++;
                end else begin
                    chk("hs_addr", 32'(o_dump_addr), 32'(hs));
                    chk("hs_data", 32'(o_dump_data), 32'h000A + 32'(hs));
                    hs++;
                end
            end
            if (o_dump_done) begin
                done_cnt++;
                got_done = 1;
                chk("done_halted", 32'(o_halted), 32'd1);
            end
            advance();
        end
        chk("dump_done_seen", 32'(got_done), 32'd1);
        chk("dump_handshakes", 32'(hs), 32'd4);
        chk("dump_stalls", 32'(stall), 32'd2);
        settle();
        chk("done_single", 32'(o_dump_done), 32'd0);
        chk("back_in_halt", 32'(o_halted), 32'd1);
        advance();
        cpu_wr = 1'b0;

        // Reset in the middle of a dump at word 2
        rst = 1'b1; cyc(); rst = 1'b0;
        cmd_dump = 1'b1; dump_ready = 1'b1;
        cyc();
        cmd_dump = 1'b0;
        got_done = 0;
        for (int c = 0; c < 30 && !got_done; c++) begin
            dump_ready = (m_ptr < 2);
            settle();
            if (o_dump_valid && o_dump_addr == 11'd2) got_done = 1;
            advance();
        end
        chk("reached_word2", 32'(got_done), 32'd1);
        rst = 1'b1;
        settle(); chk("mid_rst_valid", 32'(o_dump_valid), 32'd0); advance();
        rst = 1'b0;
        cmd_dump = 1'b1;
        settle();
        chk("post_rst_valid", 32'(o_dump_valid), 32'd0);
        chk("post_rst_halted", 32'(o_halted), 32'd0);
        advance();
        cmd_dump = 1'b0;
        settle();
        chk("restart_rd", 32'(o_dm_rd), 32'd1);
        chk("restart_addr", 32'(o_dm_addr), 32'd0);
        advance();

        // Step twice
        rst = 1'b1; cyc(); rst = 1'b0;
        instr = 16'h2804; cmd_step = 1'b1;
        cyc();
        cmd_step = 1'b0;
        settle(); chk("step_en", 32'(o_cpu_en), 32'd1); advance();
        cmd_step = 1'b1;
        settle();
        chk("step_back_idle", 32'(o_cpu_en), 32'd0);
        chk("step_count1", 32'(o_cycle_count), 32'd1);
        advance();
        cmd_step = 1'b0;
        settle(); chk("step2_en", 32'(o_cpu_en), 32'd1); advance();
        settle(); chk("step_count2", 32'(o_cycle_count), 32'd2); advance();

        // RUN+STEP together picks RUN; counter saturates at 15
        rst = 1'b1; cyc(); rst = 1'b0;
        cmd_run = 1'b1; cmd_step = 1'b1; instr = 16'h2001;
        cyc();
        cmd_run = 1'b0; cmd_step = 1'b0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (i == 1) chk("prio_run_en", 32'(o_cpu_en), 32'd1);
            advance();
        end
        settle(); chk("sat_count", 32'(o_cycle_count), 32'd15); advance();

        // Randomized traffic against the model
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            cmd_run    = ($urandom_range(0, 11) == 0);
            cmd_step   = ($urandom_range(0, 11) == 0);
            cmd_dump   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) instr = {5'd0, 11'($urandom)};
            else instr = {5'($urandom_range(1, 31)), 11'($urandom)};
            cpu_addr   = 11'($urandom);
            cpu_rd     = 1'($urandom);
            cpu_wr     = 1'($urandom);
            dump_ready = 1'($urandom);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
